// File: rtl/rx_pkg.sv
// Shared types and default sizing for the receive-side word-to-block assembler.
package rx_pkg;

  localparam int RX_NUM_WORDS = 4;
  localparam int RX_WORD_W    = 32;
  localparam int RX_BLOCK_W   = RX_NUM_WORDS * RX_WORD_W;

  typedef logic [RX_WORD_W-1:0]  word_t;
  typedef logic [RX_BLOCK_W-1:0] block_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } rx_state_t;

endpackage

// File: rtl/flexbyte_stp_sr.sv
// Serial-to-parallel shift register: each enabled cycle shifts the register
// left by one input chunk, so the oldest chunk ends up in the MSBs.
module flexbyte_stp_sr #(
  parameter int NUM_BYTES_IN  = 4,
  parameter int NUM_BYTES_OUT = 16
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       shift_enable,
  input  logic [NUM_BYTES_IN*8-1:0]  data_in,
  output logic [NUM_BYTES_OUT*8-1:0] data_out
);

  localparam int IN_W  = NUM_BYTES_IN * 8;
  localparam int OUT_W = NUM_BYTES_OUT * 8;

  logic [OUT_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (shift_enable) begin
      data_d = {data_q[OUT_W-IN_W-1:0], data_in};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/rx_sr.sv
// Packs NUM_WORDS inbound words into one block and hands it over with valid/ready.
// Optional sticky overrun flag is built only when RX_SR_OVERRUN_EN is defined.
module rx_sr
  import rx_pkg::*;
#(
  parameter int NUM_WORDS = RX_NUM_WORDS,
  parameter int WORD_W    = RX_WORD_W,
  localparam int BLOCK_W  = NUM_WORDS * WORD_W,
  localparam int CNT_W    = $clog2(NUM_WORDS + 1)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clear,
  input  logic [WORD_W-1:0]  data_in,
  input  logic               word_valid,
  output logic               word_ready,
  output logic [BLOCK_W-1:0] block_out,
  output logic               block_valid,
  input  logic               block_ready,
  output logic [CNT_W-1:0]   word_count,
  output logic               overrun
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;

  // In FULL the ready path goes straight through from the consumer so a new
  // word can land in the same cycle the old block leaves.
  assign word_ready = (state_q == FILL) || block_ready;
  assign accept     = word_valid && word_ready && !clear;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (clear) begin
      state_d = FILL;
      count_d = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            count_d = count_q + 1'b1;
            if (count_q == LAST_CNT) begin
              state_d = FULL;
            end
          end
        end
        FULL: begin
          if (block_ready) begin
            state_d = FILL;
            count_d = accept ? ONE_CNT : '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= FILL;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign block_valid = (state_q == FULL);
  assign word_count  = count_q;

  flexbyte_stp_sr #(
    .NUM_BYTES_IN  (WORD_W / 8),
    .NUM_BYTES_OUT (BLOCK_W / 8)
  ) u_stp_sr (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (accept),
    .data_in      (data_in),
    .data_out     (block_out)
  );

`ifdef RX_SR_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (clear) begin
      overrun_d = 1'b0;
    end else if (word_valid && !word_ready) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: doc/rx_sr.md
# rx_sr

Receive-side word-to-block assembler for the AES datapath. It accepts 32-bit words from the bus interface and packs four consecutive words into one 128-bit block. It presents the block to the cipher core with a valid/ready handshake and holds the data stable until the core consumes it. It is the inbound counterpart of the 128-to-32 transmit shift register.

## Interface
- NUM_WORDS, 4, number of words per block (≥2)
- WORD_W, 32, bits per word; block width is NUM_WORDS*WORD_W
- clk  input  1  system clock, rising-edge
- n_rst  input  1  asynchronous, active-low reset
- clear  input  1  synchronous abort; discards any partial or full block
- data_in  input  WORD_W  incoming word
- word_valid  input  1  data_in is valid this cycle
- word_ready  output  1  block can accept a word this cycle
- block_out  output  NUM_WORDS*WORD_W  assembled block; first-received word in the MSBs
- block_valid  output  1  block_out holds a complete block
- block_ready  input  1  consumer takes block_out this cycle
- word_count  output  $clog2(NUM_WORDS+1)  words held in the current block (0..NUM_WORDS)
- overrun  output  1  sticky flag: a word was offered while word_ready was low

## Operation
- Two states: FILL and FULL.
- Reset state is FILL, with word_count=0 and block_out=0.
- Word accept occurs when word_valid && word_ready. On accept:
  - block_out shifts left by WORD_W.
  - data_in enters the low WORD_W bits.
  - word_count increments.
- FILL:
  - word_ready=1 and block_valid=0.
  - An accept that brings word_count to NUM_WORDS moves the block to FULL.
- FULL:
  - block_valid=1.
  - word_ready=block_ready, a combinational path that allows back-to-back blocks.
  - block_ready alone (no accept): the block goes to FILL and word_count becomes 0. block_out is unchanged and its contents are don't-care.
  - block_ready and accept in the same cycle: the old block is consumed. The new word becomes word 1 of the next block, with word_count=1 and state FILL. The upper bits of block_out are don't-care until the block is full.
  - No block_ready: block_out and block_valid hold. word_count stays at NUM_WORDS.
- Priorities:
  - clear has priority over everything. It forces FILL with word_count=0, and the word offered in that cycle is dropped.
  - clear does not change block_out. It clears overrun when the feature is compiled in.
- block_ready while in FILL has no effect.
- word_count is never observed above NUM_WORDS. It wraps only through the FULL→FILL transitions above.

## Timing
- All outputs are registered except word_ready, which is combinational from state and block_ready.
- Reset values:
  - word_count=0, block_valid=0, block_out=0, overrun=0.
  - word_ready=1 after reset.
- Latency: block_valid rises on the clock edge that accepts the NUM_WORDS-th word, so it is visible in the next cycle.
- Throughput: one word per clock is sustained with no bubbles while block_ready is held high.
- Asynchronous reset mid-block discards the partial block immediately.

## Configuration
- RX_SR_OVERRUN_EN defined:
  - overrun is set when word_valid=1 && word_ready=0.
  - It stays set until clear or n_rst.
- RX_SR_OVERRUN_EN undefined:
  - The overrun port is still present and tied to 0.
  - No flag logic is built.

## Structure
- Package rx_pkg holds:
  - word_t and block_t typedefs.
  - the rx_state_t enum {FILL, FULL}.
  - the default NUM_WORDS and WORD_W constants.
- Sub-module flexbyte_stp_sr performs the serial-to-parallel shift:
  - parameterised in bytes in/out.
  - inputs shift_enable and data_in; output data_out.
- rx_sr holds the FSM, counter, handshake and overrun flag, and drives shift_enable with the accept signal.

## Test plan
- Reset then fill: words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F with block_ready=0:
  - block_out=0x000102030405060708090A0B0C0D0E0F.
  - block_valid=1 one cycle after the 4th accept.
  - word_count=4 and word_ready=0.
- Back-to-back: block_ready held 1 with 8 consecutive valid words:
  - two blocks are delivered.
  - word_ready stays 1 and no word is lost.
  - word 5 is accepted in the same cycle that block 1 is consumed, giving word_count=1.
- Backpressure: block held FULL for 10 cycles with word_valid=1:
  - block_out is stable.
  - word_ready=0.
  - overrun=1 with the macro defined; overrun=0 without it.
- Clear after 2 words, then 4 new words:
  - word_count=0 after clear.
  - the next block contains only the 4 new words.
  - overrun is cleared.
- Async reset asserted mid-block after 3 words:
  - all outputs return to their reset values immediately.
  - the next 4 words form a clean block.
- Simultaneous clear and word_valid in FULL with block_ready=1:
  - the word is dropped.
  - word_count=0 and block_valid=0.
